// File: rtl/pw_check_pkg.sv
// Shared types for the password policy checker.
//   cls_e   : character class produced by char_classifier
//   FM_*    : bit positions inside the 7-bit fail mask
//   state_e : accumulate/report FSM state
package pw_check_pkg;

    typedef enum logic [2:0] {
        CLS_LOWER,
        CLS_UPPER,
        CLS_DIGIT,
        CLS_SPECIAL,
        CLS_SPACE,
        CLS_ILLEGAL
    } cls_e;

    localparam int unsigned FM_W       = 7;
    localparam int unsigned FM_LEN     = 0;
    localparam int unsigned FM_VOWEL   = 1;
    localparam int unsigned FM_UPPER   = 2;
    localparam int unsigned FM_DIGIT   = 3;
    localparam int unsigned FM_SPECIAL = 4;
    localparam int unsigned FM_RUN     = 5;
    localparam int unsigned FM_ILLEGAL = 6;

    typedef enum logic {
        ST_ACCUM,
        ST_REPORT
    } state_e;

endpackage

// File: rtl/char_classifier.sv
// Combinational ASCII byte classifier.
//   data     in  8  byte to classify
//   cls      out    class (lower/upper/digit/special/space/illegal)
//   is_vowel out 1  a/e/i/o/u, plus A/E/I/O/U when VOWEL_UPPER != 0
module char_classifier
    import pw_check_pkg::*;
#(
    parameter int unsigned VOWEL_UPPER = 1
) (
    input  logic [7:0] data,
    output cls_e       cls,
    output logic       is_vowel
);

    always_comb begin
        cls      = CLS_ILLEGAL;
        is_vowel = 1'b0;
        if (data inside {[8'h61:8'h7A]}) begin
            cls      = CLS_LOWER;
            is_vowel = data inside {8'h61, 8'h65, 8'h69, 8'h6F, 8'h75};
        end else if (data inside {[8'h41:8'h5A]}) begin
            cls      = CLS_UPPER;
            is_vowel = (VOWEL_UPPER != 0) &&
                       (data inside {8'h41, 8'h45, 8'h49, 8'h4F, 8'h55});
        end else if (data inside {[8'h30:8'h39]}) begin
            cls = CLS_DIGIT;
        end else if (data == 8'h20) begin
            cls = CLS_SPACE;
        end else if (data inside {[8'h21:8'h7E]}) begin
            // printable and not alphanumeric or space
            cls = CLS_SPECIAL;
        end
    end

endmodule

// File: rtl/password_class_counter.sv
// Streaming password policy checker.
//   clk, rst_n           clock, synchronous active-low reset
//   s_valid/s_ready      input byte handshake; s_data byte, s_last end of password
//   m_valid/m_ready      result handshake
//   m_pass, m_fail_mask  verdict and per-rule failure bits
//   m_len, m_vowel_cnt   saturated length and vowel count of the password
module password_class_counter
    import pw_check_pkg::*;
#(
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned MIN_LEN     = 8,
    parameter int unsigned MIN_VOWEL   = 1,
    parameter int unsigned MIN_UPPER   = 1,
    parameter int unsigned MIN_DIGIT   = 1,
    parameter int unsigned MIN_SPECIAL = 1,
    parameter int unsigned MAX_RUN     = 3,
    parameter int unsigned VOWEL_UPPER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_pass,
    output logic [FM_W-1:0]  m_fail_mask,
    output logic [CNT_W-1:0] m_len,
    output logic [CNT_W-1:0] m_vowel_cnt
);

    localparam int unsigned RUN_W = $clog2(MAX_RUN + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    state_e           state, state_nxt;
    cls_e             cls;
    logic             is_vowel;
    logic             accept;

    logic [CNT_W-1:0] len, upper_cnt, digit_cnt, special_cnt, vowel_cnt;
    logic [CNT_W-1:0] len_inc, upper_inc, digit_inc, special_inc, vowel_inc;
    logic [7:0]       prev_byte;
    logic [RUN_W-1:0] run, run_inc;
    logic             run_viol, run_viol_inc;
    logic             illegal, illegal_inc;
    logic [FM_W-1:0]  fail_mask_c;

    char_classifier #(
        .VOWEL_UPPER (VOWEL_UPPER)
    ) u_classifier (
        .data     (s_data),
        .cls      (cls),
        .is_vowel (is_vowel)
    );

    assign accept = s_valid && s_ready;

    // Counter values including the byte currently on s_data.
    always_comb begin
        len_inc     = (len == CNT_MAX) ? len : len + CNT_W'(1);
        upper_inc   = upper_cnt;
        digit_inc   = digit_cnt;
        special_inc = special_cnt;
        vowel_inc   = vowel_cnt;
        if (cls == CLS_UPPER && upper_cnt != CNT_MAX)
            upper_inc = upper_cnt + CNT_W'(1);
        if (cls == CLS_DIGIT && digit_cnt != CNT_MAX)
            digit_inc = digit_cnt + CNT_W'(1);
        if (cls == CLS_SPECIAL && special_cnt != CNT_MAX)
            special_inc = special_cnt + CNT_W'(1);
        if (is_vowel && vowel_cnt != CNT_MAX)
            vowel_inc = vowel_cnt + CNT_W'(1);

        // len never wraps back to 0, so len == 0 marks the first byte
        if (len == '0 || s_data != prev_byte)
            run_inc = RUN_W'(1);
        else if (run == RUN_MAX)
            run_inc = run;
        else
            run_inc = run + RUN_W'(1);

        run_viol_inc = run_viol || (32'(run_inc) > MAX_RUN);
        illegal_inc  = illegal || (cls == CLS_ILLEGAL);

        fail_mask_c              = '0;
        fail_mask_c[FM_LEN]      = 32'(len_inc) < MIN_LEN;
        fail_mask_c[FM_VOWEL]    = 32'(vowel_inc) < MIN_VOWEL;
        fail_mask_c[FM_UPPER]    = 32'(upper_inc) < MIN_UPPER;
        fail_mask_c[FM_DIGIT]    = 32'(digit_inc) < MIN_DIGIT;
        fail_mask_c[FM_SPECIAL]  = 32'(special_inc) < MIN_SPECIAL;
        fail_mask_c[FM_RUN]      = run_viol_inc;
        fail_mask_c[FM_ILLEGAL]  = illegal_inc;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM:  if (accept && s_last) state_nxt = ST_REPORT;
            ST_REPORT: if (m_ready)          state_nxt = ST_ACCUM;
            default:                         state_nxt = ST_ACCUM;
        endcase
    end

    // State, counters and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_ACCUM;
            s_ready     <= 1'b0;
            m_valid     <= 1'b0;
            m_pass      <= 1'b0;
            m_fail_mask <= '0;
            m_len       <= '0;
            m_vowel_cnt <= '0;
            len         <= '0;
            upper_cnt   <= '0;
            digit_cnt   <= '0;
            special_cnt <= '0;
            vowel_cnt   <= '0;
            prev_byte   <= '0;
            run         <= '0;
            run_viol    <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_ready <= (state_nxt == ST_ACCUM);
            m_valid <= (state_nxt == ST_REPORT);

            if (state == ST_REPORT && m_ready) begin
                len         <= '0;
                upper_cnt   <= '0;
                digit_cnt   <= '0;
                special_cnt <= '0;
                vowel_cnt   <= '0;
                prev_byte   <= '0;
                run         <= '0;
                run_viol    <= 1'b0;
                illegal     <= 1'b0;
            end else if (accept) begin
                len         <= len_inc;
                upper_cnt   <= upper_inc;
                digit_cnt   <= digit_inc;
                special_cnt <= special_inc;
                vowel_cnt   <= vowel_inc;
                prev_byte   <= s_data;
                run         <= run_inc;
                run_viol    <= run_viol_inc;
                illegal     <= illegal_inc;
            end

            if (accept && s_last) begin
                m_fail_mask <= fail_mask_c;
                m_pass      <= (fail_mask_c == '0);
                m_len       <= len_inc;
                m_vowel_cnt <= vowel_inc;
            end
        end
    end

endmodule

// File: tb/tb_password_class_counter.sv
// Directed bench: three checker instances (default, CNT_W=4, VOWEL_UPPER=0)
// share one input stream; each step checks the instance it targets.
module tb_password_class_counter;

    logic       clk = 1'b0;
    logic       rst_n, s_valid, s_last, m_ready;
    logic [7:0] s_data;

    logic       a_s_ready, a_m_valid, a_m_pass;
    logic [6:0] a_mask;
    logic [5:0] a_len, a_vcnt;
    logic       c_s_ready, c_m_valid, c_m_pass;
    logic [6:0] c_mask;
    logic [3:0] c_len, c_vcnt;
    logic       n_s_ready, n_m_valid, n_m_pass;
    logic [6:0] n_mask;
    logic [5:0] n_len, n_vcnt;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    password_class_counter dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(a_m_valid), .m_ready(m_ready),
        .m_pass(a_m_pass), .m_fail_mask(a_mask), .m_len(a_len), .m_vowel_cnt(a_vcnt));

    password_class_counter #(.CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(c_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(c_m_valid), .m_ready(m_ready),
        .m_pass(c_m_pass), .m_fail_mask(c_mask), .m_len(c_len), .m_vowel_cnt(c_vcnt));

    password_class_counter #(.VOWEL_UPPER(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(n_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(n_m_valid), .m_ready(m_ready),
        .m_pass(n_m_pass), .m_fail_mask(n_mask), .m_len(n_len), .m_vowel_cnt(n_vcnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream a string; s_last on the final byte when with_last is set.
    task automatic send(input string s, input bit with_last);
        for (int i = 0; i < s.len(); i++) begin
            int to = 0;
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = s[i];
            s_last  = with_last && (i == s.len() - 1);
            while (!a_s_ready && to < 50) begin
                @(negedge clk);
                to++;
            end
            if (!a_s_ready) begin
                check("send_timeout", 32'd0, 32'd1);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called at the negedge right after the s_last beat was accepted.
    task automatic expect_a(input string tag, input int len, input int vcnt,
                            input int mask, input bit pass);
        check({tag, "_valid"}, 32'(a_m_valid), 32'd1);
        check({tag, "_len"},   32'(a_len),     32'(len));
        check({tag, "_vcnt"},  32'(a_vcnt),    32'(vcnt));
        check({tag, "_mask"},  32'(a_mask),    32'(mask));
        check({tag, "_pass"},  32'(a_m_pass),  32'(pass));
    endtask

    task automatic handshake(input string tag);
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(a_m_valid), 32'd0);
        check({tag, "_hs_ready"}, 32'(a_s_ready), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", 32'(a_s_ready), 32'd0);
        check("rst_m_valid", 32'(a_m_valid), 32'd0);
        check("rst_m_pass",  32'(a_m_pass),  32'd0);
        check("rst_mask",    32'(a_mask),    32'd0);
        check("rst_len",     32'(a_len),     32'd0);
        check("rst_vcnt",    32'(a_vcnt),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(a_s_ready), 32'd1);

        send("Passw0rd!", 1'b1);
        expect_a("pw1", 9, 1, 'h00, 1'b1);
        handshake("pw1");

        send("abc", 1'b1);
        expect_a("abc", 3, 1, 'h1D, 1'b0);
        handshake("abc");

        send("aaaa1A!x", 1'b1);
        expect_a("run", 8, 5, 'h20, 1'b0);
        check("run_nv_vcnt", 32'(n_vcnt), 32'd4);
        handshake("run");

        send("Pass\t0rd!", 1'b1);
        expect_a("tab", 9, 1, 'h40, 1'b0);
        handshake("tab");

        // Backpressure: result must hold while m_ready stays low.
        send("Passw0rd!", 1'b1);
        expect_a("bp", 9, 1, 'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(a_m_valid), 32'd1);
            check("bp_hold_len",   32'(a_len),     32'd9);
            check("bp_hold_mask",  32'(a_mask),    32'd0);
            check("bp_hold_pass",  32'(a_m_pass),  32'd1);
            check("bp_hold_ready", 32'(a_s_ready), 32'd0);
        end
        handshake("bp");
        send("Passw0rd!", 1'b1);
        expect_a("bp_again", 9, 1, 'h00, 1'b1);
        handshake("bp_again");

        // 20 bytes: narrow instance saturates at 15, default one counts 20.
        send("b1B!b1B!b1B!b1B!b1B!", 1'b1);
        expect_a("sat_a", 20, 0, 'h02, 1'b0);
        check("sat_c_valid", 32'(c_m_valid), 32'd1);
        check("sat_c_len",   32'(c_len),     32'd15);
        check("sat_c_mask",  32'(c_mask),    32'h02);
        check("sat_c_vcnt",  32'(c_vcnt),    32'd0);
        handshake("sat");

        // Reset mid-password: partial bytes must not leak into the next result.
        send("Pas", 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(a_m_valid), 32'd0);
        check("mid_rst_ready", 32'(a_s_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send("abc", 1'b1);
        expect_a("after_rst", 3, 1, 'h1D, 1'b0);
        handshake("after_rst");

        // Uppercase vowels ignored when VOWEL_UPPER=0.
        send("PASSW0RD!", 1'b1);
        expect_a("upv_a", 9, 1, 'h00, 1'b1);
        check("upv_n_valid", 32'(n_m_valid), 32'd1);
        check("upv_n_vcnt",  32'(n_vcnt),    32'd0);
        check("upv_n_mask",  32'(n_mask),    32'h02);
        check("upv_n_pass",  32'(n_m_pass),  32'd0);
        handshake("upv");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
